// File: rtl/sign_extend_4bit.sv
`default_nettype none
// ============================================================================
//  Module   : sign_extend_4bit
//  Purpose  : Sign-extends an IN_W-bit two's-complement immediate to an
//             OUT_W-bit datapath word. B is a pure combinational result that
//             does not depend on the clock or reset. A registered copy of B,
//             with valid, negative and zero flags, is provided for pipelined
//             consumers.
//  Ports    : clk       - clock, rising edge (registered path only)
//             rst       - synchronous active-high reset (registered path only)
//             A         - IN_W-bit two's-complement input field
//             B         - OUT_W-bit combinational sign-extended result
//             in_valid  - capture strobe for the registered path
//             B_q       - registered sign-extended result
//             q_valid   - B_q was captured on the most recent edge
//             q_neg     - registered sign bit of the captured A
//             q_zero    - registered flag, captured A was zero
//  Revision : 1.0 - initial release
// ============================================================================
module sign_extend_4bit #(
   parameter int IN_W  = 4,   // must satisfy 1 <= IN_W < OUT_W
   parameter int OUT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  A,
   output logic [OUT_W-1:0] B,
   input  logic             in_valid,
   output logic [OUT_W-1:0] B_q,
   output logic             q_valid,
   output logic             q_neg,
   output logic             q_zero
);

   localparam int EXT_W = OUT_W - IN_W;

   logic [OUT_W-1:0] data_d,  data_q;
   logic             valid_d, valid_q;
   logic             neg_d,   neg_q;
   logic             zero_d,  zero_q;

   // Replicating the sign bit keeps the numeric value: signed(B) == signed(A).
   // Continuous assignment only, so B is valid even with clk/rst floating.
   assign B = {{EXT_W{A[IN_W-1]}}, A};

   // Next-state: data and flags hold when no strobe, valid is a one-cycle pulse
   // per captured value.
   always_comb begin
      data_d  = data_q;
      neg_d   = neg_q;
      zero_d  = zero_q;
      valid_d = 1'b0;
      if (in_valid) begin
         data_d  = B;
         neg_d   = A[IN_W-1];
         zero_d  = (A == '0);
         valid_d = 1'b1;
      end
   end

   // Reset takes priority over a simultaneous capture strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         neg_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         neg_q   <= neg_d;
         zero_q  <= zero_d;
      end
   end

   assign B_q     = data_q;
   assign q_valid = valid_q;
   assign q_neg   = neg_q;
   assign q_zero  = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_sign_extend_4bit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sign_extend_4bit
//  Purpose  : Self-checking bench for sign_extend_4bit. Expected values come
//             from a numeric reference model (signed value of a 4-bit field,
//             re-encoded as a 16-bit word) and a behavioural register model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sign_extend_4bit;

   logic        clk_raw = 1'b0;
   logic        clk_en  = 1'b0;
   logic        clk;
   logic        rst = 1'b0;
   logic [3:0]  A = 4'd0;
   logic        in_valid = 1'b0;
   logic [15:0] B;
   logic [15:0] B_q;
   logic        q_valid, q_neg, q_zero;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_raw = ~clk_raw;
   assign clk = clk_raw & clk_en;

   sign_extend_4bit #(.IN_W(4), .OUT_W(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .A        (A),
      .B        (B),
      .in_valid (in_valid),
      .B_q      (B_q),
      .q_valid  (q_valid),
      .q_neg    (q_neg),
      .q_zero   (q_zero)
   );

   // Numeric value of a 4-bit two's-complement field.
   function automatic int val4(input logic [3:0] a);
      return (int'(a) >= 8) ? int'(a) - 16 : int'(a);
   endfunction

   // 16-bit two's-complement encoding of that value.
   function automatic logic [15:0] ref_ext(input logic [3:0] a);
      int v;
      v = val4(a);
      if (v < 0) return 16'(65536 + v);
      return 16'(v);
   endfunction

   task automatic test_comb_directed();
      logic [3:0]  vals [6] = '{4'b0111, 4'b1000, 4'b0010, 4'b0111, 4'b0000, 4'b1111};
      logic [15:0] exps [6] = '{16'h0007, 16'hFFF8, 16'h0002, 16'h0007, 16'h0000, 16'hFFFF};
      clk_en = 1'b0; rst = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         A = vals[i];
         #10;
         n_checks++;
         if (B !== exps[i]) begin
            n_fail++;
            $display("FAIL comb_directed[%0d]: A=%b B=%h expected %h", i, vals[i], B, exps[i]);
         end
      end
   endtask

   task automatic test_comb_exhaustive();
      for (int i = 0; i < 16; i++) begin
         A = 4'(i);
         #1;
         n_checks++;
         if (int'($signed(B)) !== val4(A)) begin
            n_fail++;
            $display("FAIL comb_value: A=%b signed(B)=%0d expected %0d", A, $signed(B), val4(A));
         end
         n_checks++;
         if (B !== ref_ext(A)) begin
            n_fail++;
            $display("FAIL comb_word: A=%b B=%h expected %h", A, B, ref_ext(A));
         end
      end
   endtask

   task automatic test_reset();
      clk_en = 1'b1;
      @(negedge clk_raw);
      rst = 1'b1; in_valid = 1'b1; A = 4'b1000;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         n_checks++;
         if ({B_q, q_valid, q_neg, q_zero} !== {16'h0000, 3'b000}) begin
            n_fail++;
            $display("FAIL reset[%0d]: B_q=%h v=%b n=%b z=%b expected all zero", c, B_q, q_valid, q_neg, q_zero);
         end
         n_checks++;
         if (B !== 16'hFFF8) begin
            n_fail++;
            $display("FAIL reset_comb[%0d]: B=%h expected fff8", c, B);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  vals [3] = '{4'b1000, 4'b0000, 4'b0101};
      logic [15:0] exps [3] = '{16'hFFF8, 16'h0000, 16'h0005};
      logic [2:0]  flg  [3] = '{3'b110, 3'b101, 3'b100}; // {valid, neg, zero}
      @(negedge clk_raw);
      rst = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         A = vals[i];
         @(posedge clk); #1;
         n_checks++;
         if ({B_q, q_valid, q_neg, q_zero} !== {exps[i], flg[i]}) begin
            n_fail++;
            $display("FAIL back_to_back[%0d]: B_q=%h vnz=%b%b%b expected %h vnz=%b",
                     i, B_q, q_valid, q_neg, q_zero, exps[i], flg[i]);
         end
         @(negedge clk_raw);
      end
   endtask

   task automatic test_hold_and_reset();
      A = 4'b1110; in_valid = 1'b1; rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ({B_q, q_valid, q_neg, q_zero} !== {16'hFFFE, 3'b110}) begin
         n_fail++;
         $display("FAIL hold_capture: B_q=%h vnz=%b%b%b expected fffe vnz=110", B_q, q_valid, q_neg, q_zero);
      end
      @(negedge clk_raw);
      in_valid = 1'b0; A = 4'b0011;
      @(posedge clk); #1;
      n_checks++;
      if ({B_q, q_valid, q_neg, q_zero} !== {16'hFFFE, 3'b010}) begin
         n_fail++;
         $display("FAIL hold: B_q=%h vnz=%b%b%b expected fffe vnz=010", B_q, q_valid, q_neg, q_zero);
      end
      @(negedge clk_raw);
      in_valid = 1'b1; A = 4'b0101;
      @(posedge clk); #1;
      @(negedge clk_raw);
      rst = 1'b1; A = 4'b1001;
      @(posedge clk); #1;
      n_checks++;
      if ({B_q, q_valid, q_neg, q_zero} !== {16'h0000, 3'b000}) begin
         n_fail++;
         $display("FAIL mid_reset: B_q=%h vnz=%b%b%b expected all zero", B_q, q_valid, q_neg, q_zero);
      end
      n_checks++;
      if (B !== 16'hFFF9) begin
         n_fail++;
         $display("FAIL mid_reset_comb: B=%h expected fff9", B);
      end
      @(negedge clk_raw);
      rst = 1'b0;
   endtask

   task automatic test_random();
      logic [15:0] m_bq;
      logic        m_v, m_n, m_z;
      logic        r_rst, r_iv;
      logic [3:0]  r_a;
      // Known starting point: the previous task left the registers reset.
      m_bq = 16'h0000; m_v = 1'b0; m_n = 1'b0; m_z = 1'b0;
      for (int c = 0; c < 300; c++) begin
         r_rst = ($urandom_range(0, 15) == 0);
         r_iv  = ($urandom_range(0, 2) != 0);
         r_a   = 4'($urandom_range(0, 15));
         rst = r_rst; in_valid = r_iv; A = r_a;
         if (r_rst) begin
            m_bq = 16'h0000; m_v = 1'b0; m_n = 1'b0; m_z = 1'b0;
         end else if (r_iv) begin
            m_bq = ref_ext(r_a);
            m_v  = 1'b1;
            m_n  = (val4(r_a) < 0);
            m_z  = (val4(r_a) == 0);
         end else begin
            m_v = 1'b0;
         end
         @(posedge clk); #1;
         n_checks++;
         if ({B_q, q_valid, q_neg, q_zero} !== {m_bq, m_v, m_n, m_z}) begin
            n_fail++;
            $display("FAIL random[%0d]: B_q=%h vnz=%b%b%b expected %h vnz=%b%b%b",
                     c, B_q, q_valid, q_neg, q_zero, m_bq, m_v, m_n, m_z);
         end
         n_checks++;
         if (B !== ref_ext(r_a)) begin
            n_fail++;
            $display("FAIL random_comb[%0d]: B=%h expected %h", c, B, ref_ext(r_a));
         end
         @(negedge clk_raw);
      end
      rst = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      test_comb_directed();
      test_comb_exhaustive();
      test_reset();
      test_back_to_back();
      test_hold_and_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
